// File: rtl/wb_uart_loader.sv
// wb_uart_loader: UART boot loader that assembles framed firmware words and writes them
// over Wishbone, holding the CPU in reset until a frame with a good checksum lands.
module wb_uart_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 2048,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, WRITE, CSUM, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] count_q, count_d, idx_q, idx_d, len;
  logic [1:0]  bidx_q, bidx_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] idle_q, idle_d;
  logic [31:0] word_q, word_d, addr_q, addr_d, data_q, data_d;
  logic        cyc_q, cyc_d, cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic        acc, timed, expire;
  assign rx_ready_o = (state_q != WRITE) && (state_q != DONE);
  assign acc        = rx_valid_i && rx_ready_o;
  assign timed      = state_q inside {LEN0, LEN1, DATA, CSUM};
  assign expire     = timed && (idle_q == TIMEOUT_CYCLES - 24'd1);
  assign len        = {rx_data_i, count_q[7:0]};
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = data_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = cyc_q;
  assign wb_sel_o   = {4{cyc_q}};
  assign cpu_rst_o  = cpu_rst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    bidx_d    = bidx_q;
    csum_d    = csum_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cyc_d     = cyc_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    idle_d    = (!timed || acc) ? '0 : idle_q + 24'd1;
    // an expiring idle counter beats any byte arriving on the same edge
    if (expire) begin
      state_d = SYNC;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        SYNC: if (acc && rx_data_i == 8'h55) begin
          state_d = LEN0;
          err_d   = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
          bidx_d  = '0;
        end
        LEN0: if (acc) begin
          count_d = {count_q[15:8], rx_data_i};
          state_d = LEN1;
        end
        LEN1: if (acc) begin
          count_d = len;
          state_d = (len == '0 || len > 16'(MAX_WORDS)) ? SYNC : DATA;
          err_d   = (len == '0 || len > 16'(MAX_WORDS));
        end
        DATA: if (acc) begin
          word_d[{bidx_q, 3'b000} +: 8] = rx_data_i;
          csum_d = csum_q + rx_data_i;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = WRITE;
            cyc_d   = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            data_d  = word_d;
          end
        end
        WRITE: if (wb_ack_i) begin
          cyc_d   = 1'b0;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == count_q) ? CSUM : DATA;
        end
        CSUM: if (acc) begin
          state_d   = (rx_data_i == csum_q) ? DONE : SYNC;
          cpu_rst_d = (rx_data_i != csum_q);
          done_d    = (rx_data_i == csum_q);
          err_d     = (rx_data_i != csum_q);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SYNC;
      count_q   <= '0;
      idx_q     <= '0;
      bidx_q    <= '0;
      csum_q    <= '0;
      idle_q    <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cyc_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      bidx_q    <= bidx_d;
      csum_q    <= csum_d;
      idle_q    <= idle_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cyc_q     <= cyc_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule
